// File: rtl/pipelined_slice_adder_if.sv
// Operand/result bundle for pipelined_slice_adder.
//
// master : the producer/consumer side. It drives the operands and in_valid,
//          drives out_ready, and observes in_ready and the result bundle.
// slave  : the adder itself.
//
// Signals:
//   in_valid / in_ready   : operand handshake
//   A, B                  : WIDTH-bit operands
//   c_in                  : carry-in, used for add only
//   sub                   : 0 = A+B+c_in, 1 = A-B
//   out_valid / out_ready : result handshake
//   S                     : WIDTH-bit sum or difference
//   c_out                 : carry out of the MSB (for sub, 1 = no borrow)
//   ovf                   : two's-complement overflow
//   sub_out               : sub flag that travelled with the result
interface pipelined_slice_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             c_out;
  logic             ovf;
  logic             sub_out;

  modport master (
    output in_valid, A, B, c_in, sub, out_ready,
    input  in_ready, out_valid, S, c_out, ovf, sub_out
  );

  modport slave (
    input  in_valid, A, B, c_in, sub, out_ready,
    output in_ready, out_valid, S, c_out, ovf, sub_out
  );
endinterface

// File: rtl/pipelined_slice_adder.sv
// Pipelined add/subtract unit with valid/ready handshakes on both sides.
//
// The WIDTH-bit datapath is cut into STAGES = WIDTH/SLICE slices. Stage k adds
// operand bits [k*SLICE +: SLICE] with the carry registered by stage k-1 and
// registers the result, so the carry ripples through the pipeline registers.
// Latency is STAGES cycles, throughput one operation per clock.
//
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high; clears every stage (valid and data)
//   bus   : pipelined_slice_adder_if.slave -- operand and result bundles
//
// The whole pipeline advances on one global enable, advance = !out_valid ||
// out_ready, which is also in_ready. When the result is stalled every stage
// holds, so a full pipeline freezes without losing or duplicating anything.
module pipelined_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  pipelined_slice_adder_if.slave  bus
);

  localparam int SLICE_SAFE = (SLICE < 1) ? 1 : SLICE;
  localparam int STAGES     = WIDTH / SLICE_SAFE;

  if ((SLICE < 1) || ((WIDTH % SLICE_SAFE) != 0)) begin : g_bad_params
    $fatal(1, "pipelined_slice_adder: WIDTH must be a positive multiple of SLICE");
  end

  // One pipeline stage. s holds the completed low result bits; a/b hold the
  // operands (b already inverted for subtraction) for the slices still to do.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t entry;
  stage_t last;
  logic   advance;

  assign advance = !last.valid || bus.out_ready;

  // Subtraction is A + ~B + 1, so the inversion and the forced carry happen
  // once at entry and the slices only ever add.
  always_comb begin
    entry       = '0;
    entry.valid = bus.in_valid;
    entry.sub   = bus.sub;
    entry.carry = bus.sub ? 1'b1 : bus.c_in;
    entry.a     = bus.A;
    entry.b     = bus.sub ? ~bus.B : bus.B;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    stage_t           q;
    logic [SLICE_SAFE:0] slice_sum;
    logic             carry_msb;

    if (k == 0) begin : g_src
      assign src = entry;
    end else begin : g_src
      assign src = g_stage[k-1].q;
    end

    assign slice_sum = {1'b0, src.a[k*SLICE_SAFE +: SLICE_SAFE]}
                     + {1'b0, src.b[k*SLICE_SAFE +: SLICE_SAFE]}
                     + (SLICE_SAFE+1)'(src.carry);

    // Carry into the slice's top bit, recovered from that bit's sum and inputs.
    assign carry_msb = slice_sum[SLICE_SAFE-1]
                     ^ src.a[k*SLICE_SAFE + SLICE_SAFE-1]
                     ^ src.b[k*SLICE_SAFE + SLICE_SAFE-1];

    // NOTE: nxt starts as a full copy of src so every field has a value on
    // every path; without that default the partial updates would infer latches.
    always_comb begin
      nxt                                  = src;
      nxt.s[k*SLICE_SAFE +: SLICE_SAFE]    = slice_sum[SLICE_SAFE-1:0];
      nxt.carry                            = slice_sum[SLICE_SAFE];
      nxt.ovf                              = slice_sum[SLICE_SAFE] ^ carry_msb;
    end

    // NOTE: data is cleared on reset along with the valid bit so the result
    // port reads all-zero after reset, not just out_valid=0; state updates are
    // non-blocking so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        q <= '0;
      end else if (advance) begin
        q <= nxt;
      end
    end
  end

  assign last = g_stage[STAGES-1].q;

  assign bus.in_ready  = advance;
  assign bus.out_valid = last.valid;
  assign bus.S         = last.s;
  assign bus.c_out     = last.carry;
  assign bus.ovf       = last.ovf;
  assign bus.sub_out   = last.sub;

  // The last stage has no slices left, so its pending operands are dead.
  logic unused_pending;
  assign unused_pending = ^{last.a, last.b};

endmodule

// File: doc/pipelined_slice_adder.md
Name: pipelined_slice_adder

Overview:
- Parametrised, pipelined add/subtract unit that generalises the team's fixed 4-bit ripple, lookahead and select adders to any WIDTH.
- The datapath is split into WIDTH/SLICE slices. Each slice is a SLICE-bit adder stage followed by a register, and the carry ripples stage to stage through the pipeline registers.
- Full valid/ready handshake on both sides, so it drops into the lab datapaths between a register file or FSM and a consumer, with backpressure.
- Throughput is one operation per clock. Latency is STAGES cycles.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits added per pipeline stage; STAGES = WIDTH/SLICE.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  synchronous, active-high reset; sampled on rising edge of Clk.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit can accept a bundle this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- c_in  input  1  carry-in; used for add only.
- sub  input  1  0 = A+B+c_in; 1 = A-B (A+~B+1, c_in ignored).
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts the result this cycle.
- S  output  WIDTH  sum/difference.
- c_out  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
- sub_out  output  1  sub flag of the emerging result.

Behaviour:
- Elaboration: WIDTH % SLICE != 0, or SLICE < 1, is a fatal elaboration error.
- Stage structure:
  - Stage k (0..STAGES-1) holds a valid bit, its carry, the completed low result bits [k*SLICE+SLICE-1:0], the pending high operand bits and the sub flag.
  - Operand B is inverted at entry when sub=1. The initial carry is sub ? 1 : c_in.
- Advance rule: a single global enable, advance = !out_valid || out_ready.
  - When advance=1, every stage register loads from its predecessor and stage 0 loads the input bundle with valid = in_valid.
  - When advance=0, all stage registers hold, including data and valid bits.
- Handshake:
  - in_ready = advance, purely combinational from out_valid and out_ready.
  - An input is accepted on an edge where in_valid && in_ready.
  - out_valid is the valid bit of the last stage.
  - A result is consumed on an edge where out_valid && out_ready.
  - S, c_out, ovf and sub_out are held stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - An input accepted at edge n with no stalls appears with out_valid=1 after edge n+STAGES-1.
  - STAGES=1 means the result is registered, valid the cycle after acceptance.
  - Each stall cycle adds exactly one cycle of latency.
  - Back-to-back accepts produce back-to-back results with no bubbles.
  - Bubbles (in_valid=0 while advancing) propagate as invalid stages and are never presented as results.
- Arithmetic:
  - S = (A + (sub ? ~B : B) + (sub ? 1 : c_in)) mod 2^WIDTH.
  - c_out is the final carry.
  - ovf uses the carry into and out of bit WIDTH-1, both from the last stage.
- Reset (synchronous):
  - On an edge with Reset=1, all stage valid bits clear to 0 and all stage data/carry registers clear to 0.
  - Post-reset outputs: out_valid=0, S=0, c_out=0, ovf=0, sub_out=0, in_ready=1.
  - In-flight operations are discarded, with no partial results emitted.
  - An input presented on the reset edge is not accepted.
- Simultaneous accept and consume on the same edge is legal with a full pipeline; the occupancy stays constant.
- Data on A, B, c_in and sub are don't-care when in_valid=0. Invalid stages may carry arbitrary data, but their valid bits must stay 0.

Test Plan:
- WIDTH=16, SLICE=4, out_ready=1: A=0xFFFF, B=0x0001, sub=0, c_in=0 accepted at edge 0 -> after edge 3: out_valid=1, S=0x0000, c_out=1, ovf=0; out_valid=0 the next cycle.
- Subtraction: A=0x8000, B=0x0001, sub=1, c_in=1 (ignored) -> S=0x7FFF, c_out=1, ovf=1, sub_out=1. Also A=0x0003, B=0x0005, sub=1 -> S=0xFFFE, c_out=0, ovf=0.
- Streaming: 8 consecutive random bundles, in_valid held high, out_ready=1 -> 8 consecutive out_valid cycles starting 3 cycles after the first accept, each matching the reference model in order.
- Backpressure: pipeline full, out_ready=0 for 5 cycles -> in_ready=0, with S, c_out, ovf and out_valid frozen. Then out_ready=1 -> results drain in order with no loss or duplication. Also hold A=0x7FFF, B=0x0001, sub=0 at the output -> S=0x8000, ovf=1 stays stable during the stall.
- Reset mid-operation: 3 ops in flight, Reset=1 for 1 cycle -> out_valid=0 and S=0 after the reset edge, in_ready=1, and none of the 3 ops ever emerges. A new op after reset completes normally with latency 4.
- Parameter sweep: WIDTH=8, SLICE=8 (latency 1, 0x7F+0x01 -> S=0x80, ovf=1) and WIDTH=32, SLICE=4 (latency 8, 0xFFFFFFFF+0+c_in=1 -> S=0, c_out=1).
